// File: rtl/resp_misr_pkg.sv
// Shared types and the MISR step function for the response compactor.
`timescale 1ns/1ps
package resp_misr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] POLY_DEF = 16'h1021;

  // Generic-width step: callers pass their real width and cast the result back down.
  function automatic logic [63:0] misr_step(input logic [63:0] sig,
                                            input logic [63:0] resp,
                                            input logic [63:0] poly,
                                            input int unsigned sig_w);
    logic [63:0] mask;
    logic [63:0] nxt;
    mask = (sig_w >= 64) ? '1 : ((64'd1 << sig_w) - 64'd1);
    nxt  = (sig << 1) ^ (sig[6'(sig_w - 1)] ? poly : 64'd0) ^ resp;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Signature register: loads a seed or folds one response vector per step.
`timescale 1ns/1ps
module misr_reg
  import resp_misr_pkg::*;
#(
  parameter int              SIG_W  = 16,
  parameter int              RESP_W = 8,
  parameter logic [SIG_W-1:0] POLY  = POLY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [SIG_W-1:0]  seed_i,
  input  logic              step_i,
  input  logic [RESP_W-1:0] resp_i,
  output logic [SIG_W-1:0]  sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i)
      sig_d = seed_i;
    else if (step_i)
      sig_d = SIG_W'(misr_step(64'(sig_q), 64'(resp_i), 64'(POLY), SIG_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/resp_misr_capture.sv
// Response compactor: folds a programmed number of response vectors into a MISR.
// Optional golden compare is built when MISR_GOLDEN_CHECK_EN is defined.
//   state | meaning
//   IDLE  | waiting for start, no run in progress
//   RUN   | accepting response vectors until target reached
//   DONE  | run complete, signature held until next start
`timescale 1ns/1ps
module resp_misr_capture
  import resp_misr_pkg::*;
#(
  parameter int               RESP_W = 8,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = POLY_DEF,
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [SIG_W-1:0]  seed,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
`ifdef MISR_GOLDEN_CHECK_EN
  input  logic [SIG_W-1:0]  golden,
  output logic              match,
`endif
  output logic [CNT_W-1:0]  vec_count
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] target_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;
  logic             start_ok;
  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;

  // start is only honoured outside RUN; a run cannot be restarted or reseeded.
  assign start_ok = start & (state_q != RUN);
  assign xfer     = resp_valid & ready_q;
  assign cnt_inc  = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            cnt_q <= '0;
            if (num_vec != '0) begin
              state_q  <= RUN;
              target_q <= num_vec;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              ready_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == target_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  misr_reg #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start_ok),
    .seed_i (seed),
    .step_i (xfer),
    .resp_i (resp),
    .sig_o  (signature)
  );

`ifdef MISR_GOLDEN_CHECK_EN
  logic [SIG_W-1:0] golden_q;
  logic             match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      golden_q <= '0;
      match_q  <= 1'b0;
    end else if (start_ok) begin
      golden_q <= golden;
      match_q  <= 1'b0;
    end else begin
      match_q <= (state_q == DONE) && (signature == golden_q);
    end
  end

  assign match = match_q;
`endif

  assign resp_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign vec_count  = cnt_q;

endmodule

// File: tb/tb_resp_misr_capture.sv
// Scoreboard bench for resp_misr_capture; golden/match checks are built with MISR_GOLDEN_CHECK_EN.
`timescale 1ns/1ps
module tb_resp_misr_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic [15:0] seed = '0;
  logic        resp_valid = 1'b0;
  logic [7:0]  resp = '0;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] vec_count;
`ifdef MISR_GOLDEN_CHECK_EN
  logic [15:0] golden = '0;
  logic        match;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [15:0] model_sig = '0;
  logic [15:0] exp_q[$];

  resp_misr_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_vec    (num_vec),
    .seed       (seed),
    .resp_valid (resp_valid),
    .resp       (resp),
    .resp_ready (resp_ready),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
`ifdef MISR_GOLDEN_CHECK_EN
    .golden     (golden),
    .match      (match),
`endif
    .vec_count  (vec_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [7:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, r};
  endfunction

  // Compare last cycle's expected signature, then log any transfer happening at the next edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) check("sig_step", signature, exp_q.pop_front());
    if (rst_n && resp_valid && resp_ready) begin
      model_sig = ref_step(model_sig, resp);
      exp_q.push_back(model_sig);
    end
  end

  task automatic do_start(input logic [15:0] s, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; seed = s; num_vec = n; model_sig = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] v, input int stall_max, input bit poke_start);
    bit got;
    repeat ($urandom_range(stall_max, 0)) begin
      resp_valid = 1'b0;
      resp = 8'($urandom);
      if (poke_start && $urandom_range(3, 0) == 0) begin
        start = 1'b1; seed = 16'hFFFF; num_vec = 16'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    resp = v;
    resp_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = resp_ready;
      @(posedge clk); #1;
    end
    resp_valid = 1'b0;
    if (!got) check("xfer_timeout", 0, 1);
  endtask

  logic [7:0]  vecs[10];
  logic [15:0] fresh;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_sig", signature, 16'h0000);
    check("rst_cnt", vec_count, 16'h0000);
    check("rst_ready", resp_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef MISR_GOLDEN_CHECK_EN
    check("rst_match", match, 0);
`endif
    rst_n = 1'b1;

    // resp_valid outside RUN is ignored
    resp_valid = 1'b1; resp = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    resp_valid = 1'b0;
    check("idle_ignore_sig", signature, 16'h0000);
    check("idle_ignore_cnt", vec_count, 16'h0000);

`ifdef MISR_GOLDEN_CHECK_EN
    golden = 16'h0002;
`endif
    do_start(16'h0000, 16'd2);
    check("s1_busy", busy, 1);
    check("s1_ready", resp_ready, 1);
    send(8'h01, 0, 0);
    check("s1_sig1", signature, 16'h0001);
    send(8'h00, 0, 0);
    check("s1_sig2", signature, 16'h0002);
    check("s1_done", done, 1);
    check("s1_busy_lo", busy, 0);
    check("s1_cnt", vec_count, 16'd2);
    check("s1_ready_lo", resp_ready, 0);
`ifdef MISR_GOLDEN_CHECK_EN
    @(posedge clk); #1;
    check("s1_match", match, 1);
    golden = 16'h0003;
    do_start(16'h0000, 16'd2);
    check("s1b_match_clr", match, 0);
    send(8'h01, 0, 0);
    send(8'h00, 0, 0);
    @(posedge clk); #1;
    check("s1b_match", match, 0);
`endif

    do_start(16'h8000, 16'd1);
    send(8'h00, 0, 0);
    check("fb_sig", signature, 16'h1021);
    check("fb_done", done, 1);

    do_start(16'hBEEF, 16'd0);
    check("z_done", done, 1);
    check("z_sig", signature, 16'hBEEF);
    check("z_cnt", vec_count, 16'd0);
    resp_valid = 1'b1; resp = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("z_ready", resp_ready, 0);
    end
    @(posedge clk); #1;
    resp_valid = 1'b0;
    check("z_sig_hold", signature, 16'hBEEF);

    do_start(16'(($urandom)), 16'd100);
    for (int i = 0; i < 100; i++) send(8'($urandom), 3, 1);
    check("bp_cnt", vec_count, 16'd100);
    check("bp_done", done, 1);
    check("bp_sig", signature, model_sig);

    for (int i = 0; i < 10; i++) vecs[i] = 8'($urandom);
    fresh = 16'h1234;
    for (int i = 0; i < 10; i++) fresh = ref_step(fresh, vecs[i]);
    do_start(16'h1234, 16'd10);
    for (int i = 0; i < 5; i++) send(vecs[i], 1, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mr_sig", signature, 16'h0000);
    check("mr_cnt", vec_count, 16'h0000);
    check("mr_ready", resp_ready, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_start(16'h1234, 16'd10);
    for (int i = 0; i < 10; i++) send(vecs[i], 1, 0);
    check("mr_fresh_sig", signature, fresh);
    check("mr_fresh_cnt", vec_count, 16'd10);

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
